// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encodings and the legal operand-width range.
package serial_addsub_pkg;

   localparam logic [1:0] IDLE_ENC = 2'b00;
   localparam logic [1:0] RUN_ENC  = 2'b01;
   localparam logic [1:0] DONE_ENC = 2'b10;

   typedef enum logic [1:0] {
      IDLE = IDLE_ENC,
      RUN  = RUN_ENC,
      DONE = DONE_ENC
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   function automatic bit widthInRange(input int w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single full-adder cell with its own carry flop. The carry can be preset
// (carry-in of 1 turns A + ~B into A - B) and only advances when enabled.
module serial_fa_cell (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_preset,
   input  logic i_en,
   input  logic i_a,
   input  logic i_b,
   output logic o_s,
   output logic o_cNext,
   output logic o_carry
);

   logic r_carry;

   assign o_s     = i_a ^ i_b ^ r_carry;
   assign o_cNext = (i_a & i_b) | (i_a & r_carry) | (i_b & r_carry);
   assign o_carry = r_carry;

   // Carry flop: preset on load, otherwise take the majority carry each enabled bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_carry <= 1'b0;
      end else if (i_load) begin
         r_carry <= i_preset;
      end else if (i_en) begin
         r_carry <= o_cNext;
      end
   end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Operands are captured on start, shifted
// LSB-first through one full-adder cell, and the result with carry-out and
// signed overflow is presented in parallel alongside a one-cycle done pulse.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   import serial_addsub_pkg::*;

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   if (!widthInRange(WIDTH)) begin : gBadWidth
      $error("serial_addsub: WIDTH must lie within 2..32");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_shA;
   logic [WIDTH-1:0] r_shB;
   logic [WIDTH-1:0] r_sumReg;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic w_accept;
   logic w_run;
   logic w_s;
   logic w_cNext;
   logic w_carry;

   assign w_accept = (r_state == IDLE) && start;
   assign w_run    = (r_state == RUN);

   serial_fa_cell uFaCell (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_accept),
      .i_preset (sub),
      .i_en     (w_run),
      .i_a      (r_shA[0]),
      .i_b      (r_shB[0]),
      .o_s      (w_s),
      .o_cNext  (w_cNext),
      .o_carry  (w_carry)
   );

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

   // Control FSM, operand shifters, bit counter and registered result/flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_shA    <= '0;
         r_shB    <= '0;
         r_sumReg <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_shA    <= a;
                  r_shB    <= sub ? ~b : b;
                  r_sumReg <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_sumReg <= {w_s, r_sumReg[WIDTH-1:1]};
               r_shA    <= {1'b0, r_shA[WIDTH-1:1]};
               r_shB    <= {1'b0, r_shB[WIDTH-1:1]};
               if (r_cnt == '0) begin
                  r_sum  <= '0;
                  r_cout <= 1'b0;
                  r_ovf  <= 1'b0;
               end
               if (r_cnt == CNT_LAST) begin
                  r_sum   <= {w_s, r_sumReg[WIDTH-1:1]};
                  r_cout  <= w_cNext;
                  r_ovf   <= w_carry ^ w_cNext;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH 8, 4 and 2 with hand-computed
// expected results, flags, latency and done-pulse spacing.
module tb_serial_addsub;

   logic       clk;
   logic       rst;

   logic       start8, sub8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;

   logic       start4, sub4, busy4, done4, cout4, ovf4;
   logic [3:0] a4, b4, sum4;

   logic       start2, sub2, busy2, done2, cout2, ovf2;
   logic [1:0] a2, b2, sum2;

   int compared;
   int mismatched;

   serial_addsub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sub(sub8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   serial_addsub #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .sub(sub4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   serial_addsub #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .sub(sub2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time limit so a stuck design still ends the run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected normal completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Launch one WIDTH=8 operation and wait (bounded) for done; returns at the
   // negedge of the done cycle with latency in edges after accept and busy count.
   task automatic doOp8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        output int lat, output int busyCnt);
      @(negedge clk);
      a8 = ta; b8 = tb; sub8 = ts; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8  = 1'b0;
      busyCnt = busy8 ? 1 : 0;
      lat     = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (done8) begin
            lat = n;
            break;
         end
         if (busy8) busyCnt++;
      end
   endtask

   task automatic test_reset();
      a8 = '0; b8 = '0; sub8 = 1'b0; start8 = 1'b0;
      a4 = '0; b4 = '0; sub4 = 1'b0; start4 = 1'b0;
      a2 = '0; b2 = '0; sub2 = 1'b0; start2 = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      compared += 6;
      if (busy8 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy8); end
      if (done8 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done8); end
      if (sum8 !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_sum: got %h expected 00", sum8); end
      if (cout8 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cout: got %b expected 0", cout8); end
      if (ovf8 !== 1'b0)  begin mismatched++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf8); end
      if (busy4 !== 1'b0 || busy2 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy_small: got %b%b expected 00", busy4, busy2); end
      rst = 1'b0;
   endtask

   task automatic test_add();
      int lat, bc;
      doOp8(8'h05, 8'h03, 1'b0, lat, bc);
      compared += 7;
      if (lat !== 8)      begin mismatched++; $display("[TB] FAIL add1_latency: got %0d expected 8", lat); end
      if (bc !== 8)       begin mismatched++; $display("[TB] FAIL add1_busy_cycles: got %0d expected 8", bc); end
      if (sum8 !== 8'h08) begin mismatched++; $display("[TB] FAIL add1_sum: got %h expected 08", sum8); end
      if (cout8 !== 1'b0) begin mismatched++; $display("[TB] FAIL add1_cout: got %b expected 0", cout8); end
      if (ovf8 !== 1'b0)  begin mismatched++; $display("[TB] FAIL add1_ovf: got %b expected 0", ovf8); end
      @(negedge clk);
      if (done8 !== 1'b0) begin mismatched++; $display("[TB] FAIL add1_done_width: got %b expected 0", done8); end
      if (busy8 !== 1'b0) begin mismatched++; $display("[TB] FAIL add1_busy_after: got %b expected 0", busy8); end

      doOp8(8'hFF, 8'h01, 1'b0, lat, bc);
      compared += 4;
      if (lat !== 8)      begin mismatched++; $display("[TB] FAIL add2_latency: got %0d expected 8", lat); end
      if (sum8 !== 8'h00) begin mismatched++; $display("[TB] FAIL add2_sum: got %h expected 00", sum8); end
      if (cout8 !== 1'b1) begin mismatched++; $display("[TB] FAIL add2_cout: got %b expected 1", cout8); end
      if (ovf8 !== 1'b0)  begin mismatched++; $display("[TB] FAIL add2_ovf: got %b expected 0", ovf8); end

      doOp8(8'h7F, 8'h01, 1'b0, lat, bc);
      compared += 3;
      if (sum8 !== 8'h80) begin mismatched++; $display("[TB] FAIL add3_sum: got %h expected 80", sum8); end
      if (cout8 !== 1'b0) begin mismatched++; $display("[TB] FAIL add3_cout: got %b expected 0", cout8); end
      if (ovf8 !== 1'b1)  begin mismatched++; $display("[TB] FAIL add3_ovf: got %b expected 1", ovf8); end
   endtask

   task automatic test_sub();
      int lat, bc;
      doOp8(8'h05, 8'h07, 1'b1, lat, bc);
      compared += 4;
      if (lat !== 8)      begin mismatched++; $display("[TB] FAIL sub1_latency: got %0d expected 8", lat); end
      if (sum8 !== 8'hFE) begin mismatched++; $display("[TB] FAIL sub1_sum: got %h expected fe", sum8); end
      if (cout8 !== 1'b0) begin mismatched++; $display("[TB] FAIL sub1_cout: got %b expected 0", cout8); end
      if (ovf8 !== 1'b0)  begin mismatched++; $display("[TB] FAIL sub1_ovf: got %b expected 0", ovf8); end

      doOp8(8'h80, 8'h01, 1'b1, lat, bc);
      compared += 3;
      if (sum8 !== 8'h7F) begin mismatched++; $display("[TB] FAIL sub2_sum: got %h expected 7f", sum8); end
      if (cout8 !== 1'b1) begin mismatched++; $display("[TB] FAIL sub2_cout: got %b expected 1", cout8); end
      if (ovf8 !== 1'b1)  begin mismatched++; $display("[TB] FAIL sub2_ovf: got %b expected 1", ovf8); end
   endtask

   task automatic test_ignore_start();
      int         doneCnt;
      logic [7:0] capSum;
      logic       capCout, capOvf;
      doneCnt = 0; capSum = 8'h00; capCout = 1'b1; capOvf = 1'b1;
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done8) begin
            doneCnt++;
            capSum = sum8; capCout = cout8; capOvf = ovf8;
         end
      end
      compared += 6;
      if (doneCnt !== 1)    begin mismatched++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", doneCnt); end
      if (capSum !== 8'h30) begin mismatched++; $display("[TB] FAIL ignore_sum: got %h expected 30", capSum); end
      if (capCout !== 1'b0) begin mismatched++; $display("[TB] FAIL ignore_cout: got %b expected 0", capCout); end
      if (capOvf !== 1'b0)  begin mismatched++; $display("[TB] FAIL ignore_ovf: got %b expected 0", capOvf); end
      if (sum8 !== 8'h30)   begin mismatched++; $display("[TB] FAIL ignore_sum_hold: got %h expected 30", sum8); end
      if (busy8 !== 1'b0)   begin mismatched++; $display("[TB] FAIL ignore_idle_busy: got %b expected 0", busy8); end
   endtask

   task automatic test_reset_midrun();
      int doneCnt, lat, bc;
      doneCnt = 0;
      @(negedge clk);
      a8 = 8'h7F; b8 = 8'h7F; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      compared += 5;
      if (busy8 !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", busy8); end
      if (done8 !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_done: got %b expected 0", done8); end
      if (sum8 !== 8'h00) begin mismatched++; $display("[TB] FAIL abort_sum: got %h expected 00", sum8); end
      if (cout8 !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_cout: got %b expected 0", cout8); end
      if (ovf8 !== 1'b0)  begin mismatched++; $display("[TB] FAIL abort_ovf: got %b expected 0", ovf8); end
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done8 || busy8) doneCnt++;
      end
      compared += 1;
      if (doneCnt !== 0) begin mismatched++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", doneCnt); end

      doOp8(8'h01, 8'h01, 1'b0, lat, bc);
      compared += 2;
      if (lat !== 8)      begin mismatched++; $display("[TB] FAIL abort_fresh_latency: got %0d expected 8", lat); end
      if (sum8 !== 8'h02) begin mismatched++; $display("[TB] FAIL abort_fresh_sum: got %h expected 02", sum8); end
   endtask

   task automatic test_back_to_back_w4();
      int doneCnt, lastDone;
      doneCnt = 0; lastDone = -1;
      @(negedge clk);
      a4 = 4'h9; b4 = 4'h9; sub4 = 1'b0; start4 = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done4) begin
            doneCnt++;
            compared += 4;
            if (sum4 !== 4'h2)  begin mismatched++; $display("[TB] FAIL w4_sum: got %h expected 2", sum4); end
            if (cout4 !== 1'b1) begin mismatched++; $display("[TB] FAIL w4_cout: got %b expected 1", cout4); end
            if (ovf4 !== 1'b1)  begin mismatched++; $display("[TB] FAIL w4_ovf: got %b expected 1", ovf4); end
            if (lastDone < 0) begin
               if (i !== 5) begin mismatched++; $display("[TB] FAIL w4_first_done: got edge %0d expected 5", i); end
            end else begin
               if (i - lastDone !== 6) begin mismatched++; $display("[TB] FAIL w4_spacing: got %0d expected 6", i - lastDone); end
            end
            lastDone = i;
         end
      end
      start4 = 1'b0;
      compared += 1;
      if (doneCnt !== 5) begin mismatched++; $display("[TB] FAIL w4_done_count: got %0d expected 5", doneCnt); end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_back_to_back_w2();
      int doneCnt, lastDone;
      doneCnt = 0; lastDone = -1;
      @(negedge clk);
      a2 = 2'h3; b2 = 2'h1; sub2 = 1'b0; start2 = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done2) begin
            doneCnt++;
            compared += 4;
            if (sum2 !== 2'h0)  begin mismatched++; $display("[TB] FAIL w2_sum: got %h expected 0", sum2); end
            if (cout2 !== 1'b1) begin mismatched++; $display("[TB] FAIL w2_cout: got %b expected 1", cout2); end
            if (ovf2 !== 1'b0)  begin mismatched++; $display("[TB] FAIL w2_ovf: got %b expected 0", ovf2); end
            if (lastDone < 0) begin
               if (i !== 3) begin mismatched++; $display("[TB] FAIL w2_first_done: got edge %0d expected 3", i); end
            end else begin
               if (i - lastDone !== 4) begin mismatched++; $display("[TB] FAIL w2_spacing: got %0d expected 4", i - lastDone); end
            end
            lastDone = i;
         end
      end
      start2 = 1'b0;
      compared += 1;
      if (doneCnt !== 7) begin mismatched++; $display("[TB] FAIL w2_done_count: got %0d expected 7", doneCnt); end
      repeat (6) @(negedge clk);
   endtask

   // Run every scenario in order and report.
   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_add();
      test_sub();
      test_ignore_start();
      test_reset_midrun();
      test_back_to_back_w4();
      test_back_to_back_w2();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor. Successor to the 2-bit-state serial adder FSM.
- Accepts two WIDTH-bit parallel operands and a mode bit on a start handshake.
- Processes them LSB-first, one bit per clock, through a single full-adder cell and carry flop.
- Returns a parallel sum with carry-out and signed overflow, so the datapath uses one adder cell instead of WIDTH.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high; clears all state and outputs
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; captured on accepted start
- b  in  WIDTH  operand B; captured on accepted start
- sub  in  1  0 = A+B, 1 = A-B; captured on accepted start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when result becomes valid
- sum  out  WIDTH  result; held from done until the next accepted start
- cout  out  1  final carry (for sub: 1 = no borrow, i.e. A >= B unsigned)
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; shift registers, carry and count cleared.
- Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE. Encoding is a shared localparam.
- IDLE:
  - start=1 at an edge (call it edge 0) -> RUN.
  - Load shA = a and shB = sub ? ~b : b.
  - carry = sub, cnt = 0, sum register cleared.
  - sum/cout/ovf outputs keep their previous values until the first RUN edge.
- RUN (busy=1), each edge:
  - s = shA[0] ^ shB[0] ^ carry; c = majority(shA[0], shB[0], carry).
  - sumreg = {s, sumreg[WIDTH-1:1]}; shA, shB shift right with zero fill; carry = c; cnt++.
  - On the edge where cnt == WIDTH-1, also record cin_msb = the carry before update, then -> DONE.
- DONE (entered at edge WIDTH):
  - done=1 for exactly this one cycle; busy=0.
  - sum = sumreg, cout = carry, ovf = cin_msb ^ carry; all valid in this cycle.
  - Next edge -> IDLE unconditionally.
- Latency: start accepted at edge 0 -> done high in the cycle following edge WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start while busy or done is ignored and is neither queued nor able to corrupt operands.
- start held high continuously: a new operation is accepted in each IDLE cycle.
- Changes on a, b or sub after capture have no effect on the running operation.
- Results wrap modulo 2^WIDTH. cout and ovf are both reported regardless of mode.
- Outputs are registered; no combinational path from inputs to outputs.
- cnt is $clog2(WIDTH) bits and never exceeds WIDTH-1.

Decomposition:
- Shared package/include: state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the WIDTH range-check constant.
- One natural sub-module: serial_fa_cell.
  - 1-bit full adder plus carry register.
  - Carry preset input (for sub) and enable input.
  - Outputs s and carry.
- The top level holds the FSM, counter, shift registers and result/flag registers.

Test Plan:
1. WIDTH=8, sub=0, a=0x05, b=0x03, start pulse -> busy for 8 cycles; done 8 cycles after the accept edge; sum=0x08, cout=0, ovf=0.
2. sub=0: a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
3. sub=1: a=0x05, b=0x07 -> sum=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
4. Start 0x10+0x20; pulse start with a=0xAA, b=0x55 on the 3rd RUN cycle; also change a/b mid-run -> result still 0x30; exactly one done pulse; sum holds 0x30 until the next start.
5. rst asserted on the 4th RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse follows; a fresh 0x01+0x01 then yields 0x02.
6. start held high for 30 cycles with WIDTH=4, a=0x9, b=0x9 -> done every 6 cycles; sum=0x2, cout=1, ovf=1 each time. Repeat at WIDTH=2 with a=0x3, b=0x1 -> sum=0x0, cout=1.
